// File: rtl/alu_board_seq.sv
// Board-level operand sequencer for the ALU lab: debounced buttons step through A, B and control-word
// loads, then capture the clocked ALU result. Optional result history ring buffer when HIST_EN is defined.
module alu_board_seq #(
  parameter int DATA_W     = 32,
  parameter int DEB_CYCLES = 16,
  parameter int RES_LAT    = 2,
  parameter int HIST_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_step,
  input  logic              btn_arm,
  input  logic              btn_back,
  input  logic              btn_hist,
  input  logic [DATA_W-1:0] alu_f,
  input  logic [3:0]        alu_nzcv,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_cf,
  output logic              alu_vf,
  output logic              alu_shc,
  output logic [DATA_W-1:0] disp_data,
  output logic [3:0]        led_nzcv,
  output logic [1:0]        step_cnt,
  output logic              busy
);

  localparam int DCW = $clog2(DEB_CYCLES);
  localparam int WCW = $clog2(RES_LAT + 1);

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OP = 2'd2, S_RES = 2'd3} state_t;

`ifdef HIST_EN
  localparam int NBTN = 4;
  logic [NBTN-1:0] raw;
  assign raw = {btn_hist, btn_back, btn_arm, btn_step};
`else
  localparam int NBTN = 3;
  logic [NBTN-1:0] raw;
  logic            unused_hist;
  assign raw         = {btn_back, btn_arm, btn_step};
  assign unused_hist = btn_hist ^ HIST_DEPTH[0];
`endif

  logic [NBTN-1:0] sync_1, sync_2, deb, deb_q;
  logic [DCW-1:0]  deb_cnt [NBTN];

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      deb    <= '0;
      deb_q  <= '0;
      for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      deb_q  <= deb;
      // A level change is accepted only after DEB_CYCLES consecutive differing samples.
      for (int i = 0; i < NBTN; i++) begin
        if (sync_2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync_2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic step_p, back_p, arm, unused_arm_q;
  assign step_p       = deb[0] & ~deb_q[0];
  assign arm          = deb[1];
  assign back_p       = deb[2] & ~deb_q[2];
  assign unused_arm_q = deb_q[1];

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic           capture;
  assign capture  = busy && (wcnt == '0);
  assign step_cnt = state;

`ifdef HIST_EN
  localparam int HAW = $clog2(HIST_DEPTH);
  logic              hist_p;
  logic [DATA_W+3:0] hist_mem [HIST_DEPTH];
  logic [HAW-1:0]    wr_ptr, rd_off, rd_next, rd_sel;
  logic [HAW:0]      valid_cnt;

  assign hist_p  = deb[3] & ~deb_q[3];
  // rd_off counts back from the newest entry; it wraps after the oldest valid one.
  assign rd_next = ({1'b0, rd_off} == valid_cnt - 1'b1) ? '0 : rd_off + 1'b1;
  assign rd_sel  = wr_ptr - 1'b1 - rd_next;

  // NOTE: the history storage has no reset; valid_cnt alone decides which entries are readable.
  always_ff @(posedge clk) begin
    if (capture) hist_mem[wr_ptr] <= {alu_nzcv, alu_f};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cf    <= 1'b0;
      alu_vf    <= 1'b0;
      alu_shc   <= 1'b0;
      disp_data <= '0;
      led_nzcv  <= '0;
      busy      <= 1'b0;
      wcnt      <= '0;
`ifdef HIST_EN
      wr_ptr    <= '0;
      rd_off    <= '0;
      valid_cnt <= '0;
`endif
    end else if (busy) begin
      // Buttons are ignored until the result has been captured.
      if (capture) begin
        disp_data <= alu_f;
        led_nzcv  <= alu_nzcv;
        busy      <= 1'b0;
`ifdef HIST_EN
        wr_ptr    <= wr_ptr + 1'b1;
        rd_off    <= '0;
        if (valid_cnt != (HAW + 1)'(HIST_DEPTH)) valid_cnt <= valid_cnt + 1'b1;
`endif
      end else begin
        wcnt <= wcnt - 1'b1;
      end
    end else if (back_p) begin
      case (state)
        S_B:     state <= S_A;
        S_OP:    state <= S_B;
        S_RES:   state <= S_OP;
        default: state <= S_A;
      endcase
    end else if (step_p && arm) begin
      case (state)
        S_B: begin
          alu_b     <= sw;
          disp_data <= sw;
          state     <= S_OP;
        end
        S_OP: begin
          alu_op  <= sw[6:3];
          alu_cf  <= sw[2];
          alu_vf  <= sw[1];
          alu_shc <= sw[0];
          busy    <= 1'b1;
          wcnt    <= WCW'(RES_LAT);
          state   <= S_RES;
        end
        default: begin
          alu_a     <= sw;
          disp_data <= sw;
          state     <= S_B;
        end
      endcase
    end
`ifdef HIST_EN
    else if (hist_p && state == S_RES) begin
      rd_off                <= rd_next;
      {led_nzcv, disp_data} <= hist_mem[rd_sel];
    end
`endif
  end

endmodule

// File: tb/tb_alu_board_seq.sv
// Directed bench for alu_board_seq: a latency-modelled ALU feeds alu_f/alu_nzcv, tasks drive raw buttons.
module tb_alu_board_seq;

  localparam int DATA_W = 32;
  localparam int DEB    = 16;
  localparam int LAT    = 60;
  localparam int HD     = 4;
  localparam int HOLD   = DEB + 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] sw = '0;
  logic              btn_step = 1'b0, btn_arm = 1'b0, btn_back = 1'b0, btn_hist = 1'b0;
  logic [DATA_W-1:0] alu_f;
  logic [3:0]        alu_nzcv;
  logic [DATA_W-1:0] alu_a, alu_b, disp_data;
  logic [3:0]        alu_op, led_nzcv;
  logic              alu_cf, alu_vf, alu_shc, busy;
  logic [1:0]        step_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_board_seq #(.DATA_W(DATA_W), .DEB_CYCLES(DEB), .RES_LAT(LAT), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .btn_step(btn_step), .btn_arm(btn_arm), .btn_back(btn_back), .btn_hist(btn_hist),
    .alu_f(alu_f), .alu_nzcv(alu_nzcv),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cf(alu_cf), .alu_vf(alu_vf), .alu_shc(alu_shc),
    .disp_data(disp_data), .led_nzcv(led_nzcv), .step_cnt(step_cnt), .busy(busy)
  );

  // Lab ALU stand-in: op 0 adds, anything else subtracts; output is garbage until the
  // inputs have been stable for LAT cycles.
  logic [70:0] alu_in;
  logic [70:0] alu_in_q = '0;
  int          lat_cnt = 0;
  logic [32:0] sum;
  logic        alu_ready;
  assign alu_in    = {alu_a, alu_b, alu_op, alu_cf, alu_vf, alu_shc};
  assign sum       = (alu_op == 4'd0) ? ({1'b0, alu_a} + {1'b0, alu_b})
                                      : ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1);
  assign alu_ready = (alu_in == alu_in_q) && (lat_cnt == 0);
  assign alu_f     = alu_ready ? sum[31:0] : 32'hDEAD_BEEF;
  assign alu_nzcv  = alu_ready ? {sum[31], sum[31:0] == 32'd0, sum[32], 1'b0} : 4'hF;

  always @(posedge clk) begin
    alu_in_q <= alu_in;
    if (alu_in != alu_in_q) lat_cnt <= LAT - 1;
    else if (lat_cnt != 0)  lat_cnt <= lat_cnt - 1;
  end

  logic [109:0] out_all;
  assign out_all = {alu_a, alu_b, alu_op, alu_cf, alu_vf, alu_shc, disp_data, led_nzcv, step_cnt, busy};

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic press(input logic s, input logic b, input logic h);
    @(negedge clk);
    btn_step = s; btn_back = b; btn_hist = h;
    cyc(HOLD);
    @(negedge clk);
    btn_step = 1'b0; btn_back = 1'b0; btn_hist = 1'b0;
    cyc(HOLD);
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; btn_step = 1'b0; btn_back = 1'b0; btn_hist = 1'b0; btn_arm = 1'b0; sw = '0;
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    @(negedge clk);
  endtask

  task automatic arm_on;
    @(negedge clk);
    btn_arm = 1'b1;
    cyc(HOLD);
    @(negedge clk);
  endtask

  // Presses step in S_OP, waits (bounded) for busy and returns how many cycles it stayed high.
  task automatic run_op(output int blen);
    int t;
    @(negedge clk);
    btn_step = 1'b1;
    t = 0;
    while (busy !== 1'b1 && t < HOLD + 20) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start: busy=%b after %0d cycles, want 1", busy, t); end
    btn_step = 1'b0;
    blen = 0;
    while (busy === 1'b1 && blen < 4 * LAT) begin
      blen++;
      @(negedge clk);
    end
    cyc(HOLD);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(3);
    @(negedge clk);
    n_tests++;
    if (out_all !== '0) begin n_fail++; $display("FAIL reset_held: outputs=%h want 0", out_all); end
    rst_n = 1'b1;
    cyc(2);
    @(negedge clk);
    n_tests++;
    if (out_all !== '0) begin n_fail++; $display("FAIL reset_released: outputs=%h want 0", out_all); end
  endtask

  task automatic test_arm;
    sw = 32'h5;
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (step_cnt !== 2'd0 || alu_a !== 32'h0) begin
      n_fail++; $display("FAIL disarmed_step: step_cnt=%0d alu_a=%h want 0/0", step_cnt, alu_a);
    end
    arm_on();
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (step_cnt !== 2'd1 || alu_a !== 32'h5 || disp_data !== 32'h5) begin
      n_fail++; $display("FAIL armed_step: step_cnt=%0d alu_a=%h disp=%h want 1/5/5", step_cnt, alu_a, disp_data);
    end
  endtask

  task automatic test_sequence;
    int blen;
    do_reset();
    arm_on();
    sw = 32'h0000_0005;
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (step_cnt !== 2'd1 || alu_a !== 32'h5) begin n_fail++; $display("FAIL seq_load_a: step_cnt=%0d alu_a=%h want 1/5", step_cnt, alu_a); end
    sw = 32'h0000_0003;
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (step_cnt !== 2'd2 || alu_b !== 32'h3 || disp_data !== 32'h3) begin
      n_fail++; $display("FAIL seq_load_b: step_cnt=%0d alu_b=%h disp=%h want 2/3/3", step_cnt, alu_b, disp_data);
    end
    sw = 32'h0000_0000;
    run_op(blen);
    n_tests++;
    if (blen != LAT + 1) begin n_fail++; $display("FAIL seq_busy_len: got %0d cycles want %0d", blen, LAT + 1); end
    n_tests++;
    if (step_cnt !== 2'd3 || disp_data !== 32'h8 || led_nzcv !== 4'h0) begin
      n_fail++; $display("FAIL seq_capture: step_cnt=%0d disp=%h led=%h want 3/8/0", step_cnt, disp_data, led_nzcv);
    end
  endtask

  task automatic test_bounce;
    sw = 32'h40;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn_step = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    btn_step = 1'b1;
    cyc(HOLD + 4);
    @(negedge clk);
    btn_step = 1'b0;
    cyc(HOLD);
    @(negedge clk);
    n_tests++;
    if (step_cnt !== 2'd1 || alu_a !== 32'h40 || disp_data !== 32'h40) begin
      n_fail++; $display("FAIL bounce_one_step: step_cnt=%0d alu_a=%h disp=%h want 1/40/40", step_cnt, alu_a, disp_data);
    end
  endtask

  task automatic test_back;
    sw = 32'h7;
    press(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (step_cnt !== 2'd2 || alu_b !== 32'h7) begin n_fail++; $display("FAIL back_setup: step_cnt=%0d alu_b=%h want 2/7", step_cnt, alu_b); end
    sw = 32'h08;
    press(1'b1, 1'b1, 1'b0);
    n_tests++;
    if (step_cnt !== 2'd1 || alu_op !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL back_wins: step_cnt=%0d alu_op=%0d busy=%b want 1/0/0", step_cnt, alu_op, busy);
    end
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    n_tests++;
    if (step_cnt !== 2'd0 || alu_a !== 32'h40 || alu_b !== 32'h7 || disp_data !== 32'h7) begin
      n_fail++; $display("FAIL back_at_a: step_cnt=%0d alu_a=%h alu_b=%h disp=%h want 0/40/7/7", step_cnt, alu_a, alu_b, disp_data);
    end
  endtask

  task automatic test_busy;
    int t;
    sw = 32'h3;
    press(1'b1, 1'b0, 1'b0);
    sw = 32'h5;
    press(1'b1, 1'b0, 1'b0);
    sw = 32'h08;
    @(negedge clk);
    btn_step = 1'b1;
    t = 0;
    while (busy !== 1'b1 && t < HOLD + 20) begin @(negedge clk); t++; end
    btn_step = 1'b0;
    cyc(20);
    @(negedge clk);
    btn_step = 1'b1;
    btn_back = 1'b1;
    cyc(HOLD);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || step_cnt !== 2'd3 || alu_a !== 32'h3) begin
      n_fail++; $display("FAIL busy_ignores_buttons: busy=%b step_cnt=%0d alu_a=%h want 1/3/3", busy, step_cnt, alu_a);
    end
    t = 0;
    while (busy === 1'b1 && t < 4 * LAT) begin @(negedge clk); t++; end
    btn_step = 1'b0;
    btn_back = 1'b0;
    cyc(HOLD);
    @(negedge clk);
    n_tests++;
    if (step_cnt !== 2'd3 || alu_op !== 4'd1 || disp_data !== 32'hFFFF_FFFE || led_nzcv !== 4'h8) begin
      n_fail++; $display("FAIL busy_capture: step_cnt=%0d op=%0d disp=%h led=%h want 3/1/fffffffe/8", step_cnt, alu_op, disp_data, led_nzcv);
    end
  endtask

  task automatic test_reset_mid_wait;
    int t;
    sw = 32'h9;
    press(1'b1, 1'b0, 1'b0);
    sw = 32'h1;
    press(1'b1, 1'b0, 1'b0);
    sw = 32'h0;
    @(negedge clk);
    btn_step = 1'b1;
    t = 0;
    while (busy !== 1'b1 && t < HOLD + 20) begin @(negedge clk); t++; end
    btn_step = 1'b0;
    cyc(10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_all !== '0) begin n_fail++; $display("FAIL reset_mid_wait: outputs=%h want 0", out_all); end
    cyc(2);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(LAT + 20);
    @(negedge clk);
    n_tests++;
    if (out_all !== '0) begin n_fail++; $display("FAIL no_capture_after_reset: outputs=%h want 0", out_all); end
  endtask

  task automatic test_hist;
    int blen;
    logic [31:0] exp_h [4];
`ifdef HIST_EN
    exp_h = '{32'h41, 32'h31, 32'h21, 32'h51};
`else
    exp_h = '{32'h51, 32'h51, 32'h51, 32'h51};
`endif
    do_reset();
    arm_on();
    for (int i = 1; i <= 5; i++) begin
      sw = 32'(i << 4);
      press(1'b1, 1'b0, 1'b0);
      sw = 32'h1;
      press(1'b1, 1'b0, 1'b0);
      sw = 32'h0;
      run_op(blen);
      n_tests++;
      if (disp_data !== 32'((i << 4) + 1)) begin
        n_fail++; $display("FAIL hist_result_%0d: disp=%h want %h", i, disp_data, 32'((i << 4) + 1));
      end
    end
    for (int k = 0; k < 4; k++) begin
      press(1'b0, 1'b0, 1'b1);
      n_tests++;
      if (disp_data !== exp_h[k] || step_cnt !== 2'd3) begin
        n_fail++; $display("FAIL hist_browse_%0d: disp=%h step_cnt=%0d want %h/3", k, disp_data, step_cnt, exp_h[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_sequence();
    test_bounce();
    test_back();
    test_busy();
    test_reset_mid_wait();
    test_hist();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
